// File: rtl/sync_write_pkg.sv
// Shared state encoding for the serial chip writers.
// Optional latch phase: SYNC_SHIFT_WRITE_LATCH_EN.
package sync_write_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_DATA  = 2'd1,
    SET_CLOCK = 2'd2,
    LATCH     = 2'd3
  } write_state_e;

endpackage

// File: rtl/edge_detector.sv
// Registered rising-edge detector, one flag per input bit.
// No configuration macros.
module edge_detector #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/sync_shift_write.sv
// Paced parallel-to-serial chip writer, two i_sync ticks per bit.
// Define SYNC_SHIFT_WRITE_LATCH_EN for a trailing latch strobe.
module sync_shift_write
  import sync_write_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sync,
  output logic                  o_clk,
  output logic                  o_data,
  output logic                  o_ready,
  output logic                  o_done
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
  ,
  output logic                  o_latch
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  write_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  write_rise;

  edge_detector #(
    .WIDTH(1)
  ) u_edge (
    .clk   (clk),
    .rst   (rst),
    .sig_i (i_write),
    .rise_o(write_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_rise) begin
          sr_d    = i_data;
          cnt_d   = '0;
          state_d = SET_DATA;
        end
      end
      SET_DATA: begin
        if (i_sync) state_d = SET_CLOCK;
      end
      SET_CLOCK: begin
        if (i_sync) begin
          if (cnt_q == LAST) begin
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
            state_d = LATCH;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            sr_d    = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            state_d = SET_DATA;
          end
        end
      end
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
      LATCH: begin
        if (i_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The last bit is never shifted out, so o_data holds it while idle.
  assign o_data  = MSB_FIRST ? sr_q[DATA_WIDTH-1] : sr_q[0];
  assign o_ready = (state_q == IDLE);
  assign o_clk   = (state_q == SET_CLOCK);
  assign o_done  = done_q;
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
  assign o_latch = (state_q == LATCH);
`endif

endmodule

// File: tb/tb_sync_shift_write.sv
// Directed plus randomized bench for sync_shift_write, MSB- and LSB-first.
// Honours SYNC_SHIFT_WRITE_LATCH_EN when defined.
module tb_sync_shift_write;

  logic       clk;
  logic       rst;
  logic       i_write;
  logic [7:0] i_data;
  logic       i_sync;
  logic       o_clk_m, o_data_m, o_ready_m, o_done_m;
  logic       o_clk_l, o_data_l, o_ready_l, o_done_l;
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
  logic       o_latch_m, o_latch_l;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit last_m = 1'b0;
  bit last_l = 1'b0;

  sync_shift_write #(
    .DATA_WIDTH(8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_write(i_write),
    .i_data (i_data),
    .i_sync (i_sync),
    .o_clk  (o_clk_m),
    .o_data (o_data_m),
    .o_ready(o_ready_m),
    .o_done (o_done_m)
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
    ,
    .o_latch(o_latch_m)
`endif
  );

  sync_shift_write #(
    .DATA_WIDTH(8),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk    (clk),
    .rst    (rst),
    .i_write(i_write),
    .i_data (i_data),
    .i_sync (i_sync),
    .o_clk  (o_clk_l),
    .o_data (o_data_l),
    .o_ready(o_ready_l),
    .o_done (o_done_l)
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
    ,
    .o_latch(o_latch_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge o_clk_m) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctl = {o_clk, o_ready, o_done, o_latch}, same on both instances.
  task automatic expect_st(string tag, bit c, bit r, bit d, bit l,
                           bit dm, bit dl);
    logic lat_m, lat_l;
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
    lat_m = o_latch_m;
    lat_l = o_latch_l;
`else
    lat_m = 1'b0;
    lat_l = 1'b0;
`endif
    chk({tag, ".ctl_m"}, {o_clk_m, o_ready_m, o_done_m, lat_m},
        {c, r, d, l});
    chk({tag, ".ctl_l"}, {o_clk_l, o_ready_l, o_done_l, lat_l},
        {c, r, d, l});
    chk({tag, ".dat_m"}, o_data_m, dm);
    chk({tag, ".dat_l"}, o_data_l, dl);
  endtask

  // One word: MSB instance emits w[7-k], LSB instance emits w[k].
  task automatic send(input logic [7:0] w, input int per, input int inj,
                      input int abort_at, input bit sync_w,
                      input bit hold);
    pulses  = 0;
    i_data  = w;
    i_write = 1'b1;
    i_sync  = sync_w;
    tick();
    i_sync = 1'b0;
    if (!hold) i_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_m = 1'b0;
        last_l = 1'b0;
        expect_st("abort", 0, 1, 0, 0, 0, 0);
        tick();
        expect_st("abort_nodone", 0, 1, 0, 0, 0, 0);
        chk("abort_pulses", pulses, k);
        i_write = 1'b0;
        return;
      end
      expect_st("set_data", 0, 0, 0, 0, w[7-k], w[k]);
      for (int j = 1; j < per; j++) begin
        if (k == inj && j == 1) begin
          i_data  = 8'hFF;
          i_write = 1'b1;
        end else if (k == inj && j == 2) begin
          i_write = 1'b0;
        end
        tick();
        expect_st("hold_data", 0, 0, 0, 0, w[7-k], w[k]);
      end
      i_sync = 1'b1;
      tick();
      i_sync = 1'b0;
      expect_st("set_clock", 1, 0, 0, 0, w[7-k], w[k]);
      for (int j = 1; j < per; j++) begin
        tick();
        expect_st("hold_clock", 1, 0, 0, 0, w[7-k], w[k]);
      end
      i_sync = 1'b1;
      tick();
      i_sync = 1'b0;
    end
`ifdef SYNC_SHIFT_WRITE_LATCH_EN
    expect_st("latch", 0, 0, 0, 1, w[0], w[7]);
    for (int j = 1; j < per; j++) begin
      tick();
      expect_st("latch_hold", 0, 0, 0, 1, w[0], w[7]);
    end
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
`endif
    last_m = w[0];
    last_l = w[7];
    expect_st("done", 0, 1, 1, 0, last_m, last_l);
    chk("pulses", pulses, 8);
    tick();
    expect_st("done_once", 0, 1, 0, 0, last_m, last_l);
    if (hold) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        expect_st("no_retrig", 0, 1, 0, 0, last_m, last_l);
      end
      i_write = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_write = 1'b0;
    i_data  = 8'h00;
    i_sync  = 1'b0;
    tick();
    tick();
    expect_st("reset", 0, 1, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    expect_st("idle", 0, 1, 0, 0, 0, 0);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    expect_st("idle_sync", 0, 1, 0, 0, 0, 0);

    send(8'hA5, 4, -1, -1, 1'b0, 1'b0);
    send(8'h00, 4, 3, -1, 1'b0, 1'b0);
    send(8'($urandom), 4, -1, 3, 1'b0, 1'b0);
    send(8'h3C, 3, -1, -1, 1'b0, 1'b0);
    send(8'($urandom), 2, -1, -1, 1'b1, 1'b0);
    send(8'($urandom), 1, -1, -1, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      send(8'($urandom), int'($urandom_range(1, 5)), -1, -1,
           1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
